// File: rtl/wb_regfile_unit_pkg.sv
// MIPS pipeline shared definitions: control-word bit positions, register index width, data width.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package wb_regfile_unit_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;

  // Control word bit positions as produced by the decode stage
  localparam int CTRL_REGWRITE = 0;
  localparam int CTRL_MEMTOREG = 1;
  localparam int CTRL_MEMREAD  = 2;
  localparam int CTRL_MEMWRITE = 3;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 5;
  localparam int CTRL_REGDST   = 6;

  // Read-port data select: r0 forces zero, an in-flight commit to the same
  // register is forwarded, otherwise the stored value is returned.
  function automatic logic [DATA_W-1:0] rd_bypass(
    input logic [REG_IDX_W-1:0] addr,
    input logic                 we,
    input logic [REG_IDX_W-1:0] wdest,
    input logic [DATA_W-1:0]    wdata,
    input logic [DATA_W-1:0]    raw
  );
    if (addr == REG_ZERO)
      return '0;
    else if (we && (addr == wdest))
      return wdata;
    else
      return raw;
  endfunction

endpackage

// File: rtl/wb_regfile_unit_regfile_2r1w.sv
// Storage array: one synchronous write port, two raw combinational read ports.
// Latency: write visible 1 edge after i_we; reads are same-cycle from storage.
// Backpressure: none, a write is accepted every cycle.
module regfile_2r1w
  import wb_regfile_unit_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [DATA_W-1:0]    i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  output logic [DATA_W-1:0]    o_rdata_a,
  output logic [DATA_W-1:0]    o_rdata_b
);

  logic [DATA_W-1:0] r_mem [NREGS];

  // Clear every entry on reset, otherwise commit the single write port
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/wb_regfile_unit.sv
// Writeback commit into the architectural register file, bypassed ID read ports, last-write record, retire counter.
// Latency: commit and record visible 1 edge after the writeback bundle; reads are combinational with same-cycle bypass.
// Backpressure: none, one writeback bundle consumed every cycle.
module wb_regfile_unit
  import wb_regfile_unit_pkg::*;
#(
  parameter int CTRL_W = 24,
  parameter int RW_BIT = CTRL_REGWRITE,
  parameter int NREGS  = 32,
  parameter int CNT_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CTRL_W-1:0]    wb_control_signals,
  input  logic [DATA_W-1:0]    wb_data,
  input  logic [REG_IDX_W-1:0] wb_destination,
  input  logic [REG_IDX_W-1:0] rs_addr,
  input  logic [REG_IDX_W-1:0] rt_addr,
  output logic [DATA_W-1:0]    rs_data,
  output logic [DATA_W-1:0]    rt_data,
  output logic                 last_wr_valid,
  output logic [REG_IDX_W-1:0] last_wr_dest,
  output logic [DATA_W-1:0]    last_wr_data,
  output logic [CNT_W-1:0]     wb_retired_count
);

  logic                 w_we;
  logic [DATA_W-1:0]    w_raw_rs;
  logic [DATA_W-1:0]    w_raw_rt;
  logic                 w_ctrl_unused;

  logic                 r_last_vld;
  logic [REG_IDX_W-1:0] r_last_dest;
  logic [DATA_W-1:0]    r_last_dat;
  logic [CNT_W-1:0]     r_count;

  // A write to r0 is dropped here so it never reaches storage, the record or the counter
  assign w_we = wb_control_signals[RW_BIT] && (wb_destination != REG_ZERO);

  // Only the RegWrite bit matters at this stage
  assign w_ctrl_unused = ^wb_control_signals;

  regfile_2r1w #(
    .NREGS (NREGS)
  ) u_rf (
    .i_clk     (clk),
    .i_reset   (reset),
    .i_we      (w_we),
    .i_waddr   (wb_destination),
    .i_wdata   (wb_data),
    .i_raddr_a (rs_addr),
    .i_raddr_b (rt_addr),
    .o_rdata_a (w_raw_rs),
    .o_rdata_b (w_raw_rt)
  );

  // Read ports: r0 masking and same-cycle write-through, each port independent
  always_comb begin
    rs_data = rd_bypass(rs_addr, w_we, wb_destination, wb_data, w_raw_rs);
    rt_data = rd_bypass(rt_addr, w_we, wb_destination, wb_data, w_raw_rt);
  end

  // Last-commit record (one-cycle pulse) and wrapping retire counter; reset beats a commit
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_vld  <= 1'b0;
      r_last_dest <= '0;
      r_last_dat  <= '0;
      r_count     <= '0;
    end else begin
      r_last_vld  <= w_we;
      r_last_dest <= w_we ? wb_destination : REG_ZERO;
      r_last_dat  <= w_we ? wb_data : '0;
      if (w_we) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign last_wr_valid    = r_last_vld;
  assign last_wr_dest     = r_last_dest;
  assign last_wr_data     = r_last_dat;
  assign wb_retired_count = r_count;

endmodule

// File: tb/tb_wb_regfile_unit.sv
// Directed bench for wb_regfile_unit: vector table for the main sequence, hand sequences for reset and counter wrap.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_regfile_unit;

  logic        clk;
  logic        reset;
  logic [23:0] ctrl;
  logic [31:0] wdata;
  logic [4:0]  wdest;
  logic [4:0]  rs_a;
  logic [4:0]  rt_a;
  logic [31:0] rs_d;
  logic [31:0] rt_d;
  logic        lw_v;
  logic [4:0]  lw_dest;
  logic [31:0] lw_dat;
  logic [31:0] cnt;

  // Second instance with a 4-bit counter for the wrap check
  logic        reset1;
  logic [23:0] ctrl1;
  logic [31:0] wdata1;
  logic [4:0]  wdest1;
  logic [4:0]  rs_a1;
  logic [4:0]  rt_a1;
  logic [31:0] rs_d1;
  logic [31:0] rt_d1;
  logic        lw_v1;
  logic [4:0]  lw_dest1;
  logic [31:0] lw_dat1;
  logic [3:0]  cnt1;

  int total;
  int bad;

  wb_regfile_unit dut (
    .clk                (clk),
    .reset              (reset),
    .wb_control_signals (ctrl),
    .wb_data            (wdata),
    .wb_destination     (wdest),
    .rs_addr            (rs_a),
    .rt_addr            (rt_a),
    .rs_data            (rs_d),
    .rt_data            (rt_d),
    .last_wr_valid      (lw_v),
    .last_wr_dest       (lw_dest),
    .last_wr_data       (lw_dat),
    .wb_retired_count   (cnt)
  );

  wb_regfile_unit #(.CNT_W(4)) dut4 (
    .clk                (clk),
    .reset              (reset1),
    .wb_control_signals (ctrl1),
    .wb_data            (wdata1),
    .wb_destination     (wdest1),
    .rs_addr            (rs_a1),
    .rt_addr            (rt_a1),
    .rs_data            (rs_d1),
    .rt_data            (rt_d1),
    .last_wr_valid      (lw_v1),
    .last_wr_dest       (lw_dest1),
    .last_wr_data       (lw_dat1),
    .wb_retired_count   (cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One record per cycle: inputs driven after the falling edge, outputs sampled
  // before the next rising edge. Registered expectations reflect earlier edges.
  typedef struct {
    logic        rst;
    logic        chk;
    logic [23:0] ctrl;
    logic [4:0]  dest;
    logic [31:0] data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] ers;
    logic [31:0] ert;
    logic        ev;
    logic [4:0]  ed;
    logic [31:0] edat;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vq[$];

  initial begin
    total  = 0;
    bad    = 0;
    reset  = 1'b1;
    ctrl   = '0;
    wdata  = '0;
    wdest  = '0;
    rs_a   = '0;
    rt_a   = '0;
    reset1 = 1'b1;
    ctrl1  = '0;
    wdata1 = '0;
    wdest1 = '0;
    rs_a1  = '0;
    rt_a1  = '0;

    //            rst  chk  ctrl        dest   data           rs     rt     ers            ert            ev    ed     edat           ecnt
    vq.push_back('{1'b1,1'b0,24'h000000,5'd0, 32'h0,         5'd0, 5'd0, 32'h0,         32'h0,         1'b0,5'd0, 32'h0,         32'd0});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd0, 32'h0,         5'd5, 5'd7, 32'h0,         32'h0,         1'b0,5'd0, 32'h0,         32'd0});
    vq.push_back('{1'b0,1'b1,24'h000001,5'd5, 32'hDEADBEEF,  5'd5, 5'd7, 32'hDEADBEEF,  32'h0,         1'b0,5'd0, 32'h0,         32'd0});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd5, 32'h0,         5'd5, 5'd5, 32'hDEADBEEF,  32'hDEADBEEF,  1'b1,5'd5, 32'hDEADBEEF,  32'd1});
    vq.push_back('{1'b0,1'b1,24'h000001,5'd0, 32'h12345678,  5'd0, 5'd0, 32'h0,         32'h0,         1'b0,5'd0, 32'h0,         32'd1});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd0, 32'h0,         5'd0, 5'd0, 32'h0,         32'h0,         1'b0,5'd0, 32'h0,         32'd1});
    vq.push_back('{1'b0,1'b1,24'h000001,5'd7, 32'h11,        5'd5, 5'd7, 32'hDEADBEEF,  32'h11,        1'b0,5'd0, 32'h0,         32'd1});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd7, 32'hFFFF0000,  5'd7, 5'd7, 32'h11,        32'h11,        1'b1,5'd7, 32'h11,        32'd2});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd7, 32'hFFFF0000,  5'd0, 5'd7, 32'h0,         32'h11,        1'b0,5'd0, 32'h0,         32'd2});
    vq.push_back('{1'b0,1'b1,24'hFFFFFE,5'd7, 32'h5555,      5'd7, 5'd7, 32'h11,        32'h11,        1'b0,5'd0, 32'h0,         32'd2});
    vq.push_back('{1'b0,1'b1,24'h000001,5'd3, 32'hA,         5'd3, 5'd3, 32'hA,         32'hA,         1'b0,5'd0, 32'h0,         32'd2});
    vq.push_back('{1'b0,1'b1,24'h000001,5'd3, 32'hB,         5'd3, 5'd3, 32'hB,         32'hB,         1'b1,5'd3, 32'hA,         32'd3});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd0, 32'h0,         5'd3, 5'd5, 32'hB,         32'hDEADBEEF,  1'b1,5'd3, 32'hB,         32'd4});
    vq.push_back('{1'b0,1'b1,24'h800001,5'd31,32'h1F1F,      5'd31,5'd0, 32'h1F1F,      32'h0,         1'b0,5'd0, 32'h0,         32'd4});
    vq.push_back('{1'b0,1'b1,24'h000000,5'd0, 32'h0,         5'd31,5'd3, 32'h1F1F,      32'hB,         1'b1,5'd31,32'h1F1F,      32'd5});

    foreach (vq[k]) begin
      @(negedge clk);
      reset = vq[k].rst;
      ctrl  = vq[k].ctrl;
      wdest = vq[k].dest;
      wdata = vq[k].data;
      rs_a  = vq[k].rs;
      rt_a  = vq[k].rt;
      #1;
      if (vq[k].chk) begin
        check($sformatf("v%0d rs_data", k), rs_d, vq[k].ers);
        check($sformatf("v%0d rt_data", k), rt_d, vq[k].ert);
        check($sformatf("v%0d last_wr_valid", k), {31'b0, lw_v}, {31'b0, vq[k].ev});
        check($sformatf("v%0d last_wr_dest", k), {27'b0, lw_dest}, {27'b0, vq[k].ed});
        check($sformatf("v%0d last_wr_data", k), lw_dat, vq[k].edat);
        check($sformatf("v%0d count", k), cnt, vq[k].ecnt);
      end
    end

    // Populate r1..r31 with distinct patterns
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      ctrl  = 24'h000001;
      wdest = 5'(i);
      wdata = 32'h01010101 * 32'(i);
    end
    @(negedge clk);
    ctrl  = '0;
    wdest = '0;
    wdata = '0;
    #1;
    check("populate count", cnt, 32'd36);
    check("populate last dest", {27'b0, lw_dest}, 32'd31);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rs_a = 5'(i);
      rt_a = 5'(32 - i);
      #1;
      check($sformatf("pop rs r%0d", i), rs_d, 32'h01010101 * 32'(i));
      check($sformatf("pop rt r%0d", 32 - i), rt_d, 32'h01010101 * 32'(32 - i));
    end

    // Reset together with a commit: reads still see the pre-reset state this cycle
    @(negedge clk);
    reset = 1'b1;
    ctrl  = 24'h000001;
    wdest = 5'd9;
    wdata = 32'h99;
    rs_a  = 5'd9;
    rt_a  = 5'd31;
    #1;
    check("rst cycle bypass r9", rs_d, 32'h99);
    check("rst cycle raw r31", rt_d, 32'h1F1F1F1F);
    @(negedge clk);
    reset = 1'b0;
    ctrl  = '0;
    wdest = '0;
    wdata = '0;
    #1;
    check("post rst r9", rs_d, 32'h0);
    check("post rst count", cnt, 32'd0);
    check("post rst valid", {31'b0, lw_v}, 32'd0);
    check("post rst last data", lw_dat, 32'd0);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      rs_a = 5'(i);
      rt_a = 5'(32 - i);
      #1;
      check($sformatf("cleared r%0d", i), rs_d, 32'h0);
    end

    // Reset held for several cycles while commits are presented
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      reset = 1'b1;
      ctrl  = 24'h000001;
      wdest = 5'd4;
      wdata = 32'h44 + 32'(i);
      rs_a  = 5'd0;
      rt_a  = 5'd6;
      #1;
      check($sformatf("held rst count %0d", i), cnt, 32'd0);
      check($sformatf("held rst valid %0d", i), {31'b0, lw_v}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    ctrl  = '0;
    rs_a  = 5'd4;
    #1;
    check("after held rst r4", rs_d, 32'h0);
    check("after held rst count", cnt, 32'd0);

    // 4-bit counter wrap: 17 commits leave the count at 1
    @(negedge clk);
    reset1 = 1'b0;
    #1;
    check("cnt4 reset", {28'b0, cnt1}, 32'd0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      ctrl1  = 24'h000001;
      wdest1 = 5'((i % 31) + 1);
      wdata1 = 32'(i) + 32'h100;
      rs_a1  = wdest1;
      #1;
      if (i == 15) check("cnt4 after 15", {28'b0, cnt1}, 32'd15);
      if (i == 16) check("cnt4 after 16 wrap", {28'b0, cnt1}, 32'd0);
    end
    check("cnt4 bypass", rs_d1, 32'h110);
    @(negedge clk);
    ctrl1 = '0;
    #1;
    check("cnt4 after 17", {28'b0, cnt1}, 32'd1);
    check("cnt4 last dest", {27'b0, lw_dest1}, 32'd17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_regfile_unit.md
Name: wb_regfile_unit

Overview:
- Consumer end of the MEM/WB pipeline interface: takes the registered writeback bundle (control word, result data, destination register) and commits it to the 32x32 architectural register file.
- Serves the ID stage with two read ports that include same-cycle write-through bypass.
- Also provides a registered "last committed write" record for the hazard/forwarding unit, and a retired-writeback counter for debug.

Parameters:
- CTRL_W, 24, width of the control word from MEM/WB
- RW_BIT, 0, index of the RegWrite bit within the control word
- NREGS, 32, number of architectural registers; register 0 is hardwired to zero
- CNT_W, 32, width of the retired-writeback counter

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- wb_control_signals  input  CTRL_W  control word from MEM/WB
- wb_data  input  32  writeback data (already muxed ALU/memory result)
- wb_destination  input  5  destination register index
- rs_addr  input  5  read port A address (ID stage)
- rt_addr  input  5  read port B address (ID stage)
- rs_data  output  32  read port A data (combinational)
- rt_data  output  32  read port B data (combinational)
- last_wr_valid  output  1  a register was committed on the previous edge
- last_wr_dest  output  5  destination of that commit
- last_wr_data  output  32  data of that commit
- wb_retired_count  output  CNT_W  number of commits since reset

Behaviour:
- Commit condition: we = wb_control_signals[RW_BIT] && (wb_destination != 0).
- Commit timing: when we is high, regs[wb_destination] <= wb_data at the rising edge. Commit latency is 1 edge.
- Register 0:
  - Never stored.
  - Reads of address 0 always return 32'h0, including under bypass.
  - A write attempt to register 0 is a non-commit: no counter increment, and last_wr_valid is 0 on the next cycle.
- Read ports are combinational:
  - If addr == 0 -> 0.
  - Else if we && addr == wb_destination -> wb_data (bypass, same cycle).
  - Else -> regs[addr].
  - Both ports bypass independently; rs_addr == rt_addr is legal.
- The last-write record is registered:
  - last_wr_valid <= we
  - last_wr_dest <= we ? wb_destination : 0
  - last_wr_data <= we ? wb_data : 0
  - Result: valid for exactly one cycle per commit.
- Counter:
  - wb_retired_count increments by 1 on each commit edge.
  - Wraps modulo 2^CNT_W with no saturation and no flag.
- Reset (synchronous):
  - At a rising edge with reset high: all regs <= 0, last_wr_valid <= 0, last_wr_dest <= 0, last_wr_data <= 0, wb_retired_count <= 0.
  - Reset wins over a simultaneous commit; the write is discarded.
  - Combinational reads during the reset cycle still reflect the pre-reset array and bypass.
  - After the reset edge, all reads return 0 until a new commit.
- Reset asserted mid-stream for several cycles: no commits occur, and the counter stays 0 throughout.
- Control bits other than RW_BIT are ignored.
- The design contains no X sources: every register has a defined reset value.

Decomposition:
- Shared package (MIPS pipeline package):
  - control-word bit index constants (RegWrite, MemToReg, etc.), so RW_BIT is taken from one source
  - REG_ZERO = 5'd0
  - the register-index width constant
- One natural sub-module, regfile_2r1w: the storage array with the write port and two raw read ports.
- The wrapper adds the bypass mux, the r0 masking, the last-write record and the counter.

Test Plan:
- Reset, then wb_control_signals[0]=1, wb_destination=5, wb_data=32'hDEADBEEF, rs_addr=5 -> in the same cycle rs_data=32'hDEADBEEF (bypass); on the next cycle rs_data is still 32'hDEADBEEF with the write deasserted, last_wr_valid=1, last_wr_dest=5, last_wr_data=32'hDEADBEEF, wb_retired_count=1.
- RegWrite=1, destination=0, data=32'h12345678, rs_addr=rt_addr=0 -> rs_data=rt_data=0 in that cycle and after; last_wr_valid=0; count unchanged.
- RegWrite=0, destination=7, data=32'hFFFF0000 with r7 previously 32'h11 -> rt_addr=7 reads 32'h11 both same cycle and next cycle; count unchanged.
- Write r3=32'hA, then next cycle write r3=32'hB while rs_addr=rt_addr=3 -> both ports show 32'hA before the edge in cycle 1, 32'hB during cycle 2 (bypass), and 32'hB afterwards.
- Populate r1..r31, then assert reset together with a write of r9=32'h99 -> after the edge every register reads 0, r9 reads 0, count=0, last_wr_valid=0.
- With CNT_W=4, perform 17 consecutive commits -> wb_retired_count reads 1 (wrapped at 16).
